rgb_fade_sequencer: RTL
=======================

Name: rgb_fade_sequencer

Overview:
Sequences one RGB LED's PWM duty values through a fixed 8-colour palette: crossfade to each colour, hold it, then advance.
- Sits between the board switches/enable and three pwm instances (red, green, blue), replacing hand-coded breathing/duty logic in top.
- Owns the tick divider, the fade/hold scheduling and a graceful fade-out on disable.

Parameters:
CLK_DIV, 100_000, clock cycles per tick (1 kHz at 100 MHz); minimum 2.
HOLD_TICKS, 500, ticks a reached colour is held before advancing; minimum 1.
STEP, 1, maximum duty change per channel per tick (1..255).

Ports:
clk  input  1  system clock
rst  input  1  reset: synchronous, active-high
en  input  1  run sequence; low = fade out to dark then idle
pause  input  1  freeze: ticks ignored, all state and outputs held
duty_r  output  8  red duty to pwm
duty_g  output  8  green duty to pwm
duty_b  output  8  blue duty to pwm
colour_idx  output  3  current target palette index
holding  output  1  high while in HOLD
cycle_done  output  1  one-cycle pulse when index wraps 7->0

Behaviour:
- Reset (one clock clk with rst=1):
  - duty_r/g/b=0, colour_idx=0, holding=0, cycle_done=0.
  - State IDLE, tick counter=0, hold counter=0.
  - Applies mid-operation from any state.
- Tick generator:
  - cnt counts 0..CLK_DIV-1 and wraps; it free-runs regardless of state.
  - tick = (cnt==CLK_DIV-1), so the first tick is CLK_DIV-1 cycles after reset release.
  - pause=1 masks tick; cnt keeps running.
- Palette, fixed, as (r,g,b) hex:
  - 0 (FF,00,00), 1 (FF,FF,00), 2 (00,FF,00), 3 (00,FF,FF)
  - 4 (00,00,FF), 5 (FF,00,FF), 6 (FF,FF,FF), 7 (40,40,40)
- Step rule, per channel, on a masked tick:
  - d<t: d += min(STEP, t-d).
  - d>t: d -= min(STEP, d-t).
  - Never overshoots; use 9-bit difference arithmetic, no wrap.
- State IDLE:
  - Duties stay 0.
  - en=1 -> FADE on the next clock, colour_idx unchanged.
- State FADE (target = palette[colour_idx]):
  - On a tick, if all three duties equal the target -> HOLD with hold counter=0.
  - Otherwise apply the step rule.
  - Arrival is therefore detected one tick after the last step.
- State HOLD:
  - holding=1.
  - On a tick, if hold counter==HOLD_TICKS-1: colour_idx+1 (7 wraps to 0 with cycle_done pulsed that cycle) and go to FADE.
  - Otherwise increment the hold counter.
- State DIM, entered from FADE or HOLD when en=0 (checked every clock, not only on ticks):
  - Target is (00,00,00); colour_idx is retained.
  - On a tick, if all duties are 0 -> IDLE, else step toward 0.
  - en=1 in DIM -> FADE next clock, toward palette[colour_idx] from the current duties.
- Simultaneous events:
  - rst dominates everything.
  - en=0 dominates a tick in the same cycle (transition to DIM; no FADE/HOLD action on that tick).
  - pause=1 with en=0 still moves to DIM, but no stepping occurs until pause=0.
- Output timing:
  - All outputs are registered.
  - Duties change on the clock edge at which a tick is sampled.
  - holding changes with the state.
- No handshake with pwm: duties are level outputs consumed continuously.

Test Plan:
Bench parameters: CLK_DIV=4, HOLD_TICKS=3, STEP=1.
- Reset then en=1: duty_r rises 00->FF one per tick (every 4 clocks), g/b stay 0. Arrival tick 256 -> holding=1. After 3 more ticks, colour_idx=1 and duty_g starts rising.
- STEP=0x80 build, en=1: duty_r sequence 80, FF (clamped), then HOLD. Next colour: duty_g 80, FF, duty_r unchanged at FF.
- Run a full palette loop: cycle_done pulses exactly once, for one clock, as colour_idx goes 7->0. Duties then fade from (40,40,40) toward (FF,00,00).
- Mid-fade at duty_r=0x30, drop en: duties step down to 0 over 48 ticks, then IDLE. Raise en: resumes FADE toward the retained colour_idx.
- Hold pause=1 for 40 clocks during FADE: duties, colour_idx and holding are constant. After release, stepping resumes at the next tick.
- Assert rst for one clock mid-HOLD at colour_idx=5: next cycle all duties 0, colour_idx=0, holding=0, state IDLE even though en=1. The fade restarts toward index 0 the following clock.

Source files
------------

// File: rtl/rgb_fade_sequencer.sv
// Crossfades one RGB LED's PWM duties through a fixed 8-colour palette: fade, hold, advance.
// Latency: every output is registered; duties move on the clock edge that samples a tick.
// Backpressure: none; duties are level outputs, and pause freezes all sequencing state.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   en                run the sequence; low fades to dark and then idles
//   pause             masks ticks; the tick divider keeps running
//   duty_r/g/b        8-bit duty values for the three pwm channels
//   colour_idx        palette index currently targeted
//   holding           high while a reached colour is being held
//   cycle_done        one-clock pulse when colour_idx wraps from 7 to 0

module rgb_fade_sequencer #(
   parameter int CLK_DIV    = 100_000,
   parameter int HOLD_TICKS = 500,
   parameter int STEP       = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       pause,
   output logic [7:0] duty_r,
   output logic [7:0] duty_g,
   output logic [7:0] duty_b,
   output logic [2:0] colour_idx,
   output logic       holding,
   output logic       cycle_done
);

   localparam int CNT_W  = $clog2(CLK_DIV);
   localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
   localparam logic [8:0]        STEP9     = 9'(STEP);

   typedef enum logic [1:0] {S_IDLE, S_FADE, S_HOLD, S_DIM} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic [7:0]        r_nxt, g_nxt, b_nxt;
   logic [2:0]        idx_nxt;
   logic              cd_nxt;
   logic              tick;
   logic [23:0]       tgt;
   logic              at_tgt;

   function automatic logic [23:0] palette(input logic [2:0] i);
      logic [23:0] c;
      case (i)
         3'd0:    c = 24'hFF0000;
         3'd1:    c = 24'hFFFF00;
         3'd2:    c = 24'h00FF00;
         3'd3:    c = 24'h00FFFF;
         3'd4:    c = 24'h0000FF;
         3'd5:    c = 24'hFF00FF;
         3'd6:    c = 24'hFFFFFF;
         default: c = 24'h404040;
      endcase
      return c;
   endfunction

   // Moves d toward t by at most STEP; the 9-bit difference keeps the clamp
   // free of wrap-around so the duty never overshoots its target.
   function automatic logic [7:0] step_toward(input logic [7:0] d, input logic [7:0] t);
      logic [8:0] diff;
      logic [7:0] res;
      diff = 9'd0;
      res  = d;
      if (d < t) begin
         diff = {1'b0, t} - {1'b0, d};
         res  = d + ((diff > STEP9) ? STEP9[7:0] : diff[7:0]);
      end else if (d > t) begin
         diff = {1'b0, d} - {1'b0, t};
         res  = d - ((diff > STEP9) ? STEP9[7:0] : diff[7:0]);
      end
      return res;
   endfunction

   // Free-running tick divider; pause only masks the tick, never the count.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (cnt == CNT_LAST)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   assign tick   = (cnt == CNT_LAST) && !pause;
   assign tgt    = (state == S_DIM) ? 24'h000000 : palette(colour_idx);
   assign at_tgt = ({duty_r, duty_g, duty_b} == tgt);

   always_comb begin
      state_nxt    = state;
      r_nxt        = duty_r;
      g_nxt        = duty_g;
      b_nxt        = duty_b;
      idx_nxt      = colour_idx;
      hold_cnt_nxt = hold_cnt;
      cd_nxt       = 1'b0;
      case (state)
         S_IDLE: begin
            r_nxt = 8'h00;
            g_nxt = 8'h00;
            b_nxt = 8'h00;
            if (en)
               state_nxt = S_FADE;
         end
         S_FADE: begin
            // en low wins over a coincident tick: no step on that edge.
            if (!en) begin
               state_nxt = S_DIM;
            end else if (tick) begin
               if (at_tgt) begin
                  state_nxt    = S_HOLD;
                  hold_cnt_nxt = '0;
               end else begin
                  r_nxt = step_toward(duty_r, tgt[23:16]);
                  g_nxt = step_toward(duty_g, tgt[15:8]);
                  b_nxt = step_toward(duty_b, tgt[7:0]);
               end
            end
         end
         S_HOLD: begin
            if (!en) begin
               state_nxt = S_DIM;
            end else if (tick) begin
               if (hold_cnt == HOLD_LAST) begin
                  idx_nxt   = colour_idx + 3'd1;
                  cd_nxt    = (colour_idx == 3'd7);
                  state_nxt = S_FADE;
               end else begin
                  hold_cnt_nxt = hold_cnt + HOLD_W'(1);
               end
            end
         end
         S_DIM: begin
            if (en) begin
               state_nxt = S_FADE;
            end else if (tick) begin
               if (at_tgt) begin
                  state_nxt = S_IDLE;
               end else begin
                  r_nxt = step_toward(duty_r, 8'h00);
                  g_nxt = step_toward(duty_g, 8'h00);
                  b_nxt = step_toward(duty_b, 8'h00);
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         hold_cnt   <= '0;
         duty_r     <= 8'h00;
         duty_g     <= 8'h00;
         duty_b     <= 8'h00;
         colour_idx <= 3'd0;
         holding    <= 1'b0;
         cycle_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         hold_cnt   <= hold_cnt_nxt;
         duty_r     <= r_nxt;
         duty_g     <= g_nxt;
         duty_b     <= b_nxt;
         colour_idx <= idx_nxt;
         holding    <= (state_nxt == S_HOLD);
         cycle_done <= cd_nxt;
      end
   end

endmodule
